// File: rtl/program_loader.sv
// Program loader: receives a framed instruction image over a byte link and
// writes it into instruction memory, holding the CPU until the load ends.
// Frame: SYNC_BYTE, count hi, count lo, N x 4 instruction bytes, XOR checksum.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'h55,
  parameter logic [15:0] MAX_WORDS = 16'd256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  output logic        oReady,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [27:0] oWriteData,
  output logic        oCpuHold,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, B0, B1, B2, B3, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state, state_nx;
  logic        accept;
  logic        is_sync;
  logic        last_word;
  logic [15:0] n_lat;
  logic [15:0] count;
  logic [15:0] addr;
  logic [27:0] word;
  logic [7:0]  csum;

  assign accept        = iByteValid && (state != WRITE);
  assign is_sync       = (iByte == SYNC_BYTE);
  assign n_lat         = {count[15:8], iByte};
  assign last_word     = ((addr + 16'd1) == count);
  assign oWriteAddress = addr;
  assign oWriteData    = word;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and output decode
  always_comb begin
    state_nx     = state;
    oReady       = 1'b1;
    oWriteEnable = 1'b0;
    oCpuHold     = 1'b1;
    oDone        = 1'b0;
    oError       = 1'b0;
    case (state)
      IDLE: begin
        oCpuHold = 1'b0;
        if (accept && is_sync) state_nx = CNT_HI;
      end
      DONE: begin
        oCpuHold = 1'b0;
        oDone    = 1'b1;
        if (accept && is_sync) state_nx = CNT_HI;
      end
      ERROR: begin
        oError = 1'b1;
        if (accept && is_sync) state_nx = CNT_HI;
      end
      CNT_HI: if (accept) state_nx = CNT_LO;
      CNT_LO: begin
        if (accept) begin
          if (n_lat == 16'd0)          state_nx = CHECK;
          else if (n_lat > MAX_WORDS)  state_nx = ERROR;
          else                         state_nx = B0;
        end
      end
      B0: if (accept) state_nx = (iByte[7:4] != 4'd0) ? ERROR : B1;
      B1: if (accept) state_nx = B2;
      B2: if (accept) state_nx = B3;
      B3: if (accept) state_nx = WRITE;
      WRITE: begin
        oReady       = 1'b0;
        oWriteEnable = 1'b1;
        state_nx     = last_word ? CHECK : B0;
      end
      CHECK: if (accept) state_nx = (iByte == csum) ? DONE : ERROR;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: word count, address counter, word assembly and running checksum
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      addr  <= '0;
      word  <= '0;
      csum  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (accept && is_sync) begin
            count <= '0;
            addr  <= '0;
            csum  <= '0;
          end
        end
        CNT_HI: begin
          if (accept) begin
            count[15:8] <= iByte;
            csum        <= csum ^ iByte;
          end
        end
        CNT_LO: begin
          if (accept) begin
            count <= n_lat;
            csum  <= csum ^ iByte;
          end
        end
        B0: begin
          if (accept) begin
            word[27:24] <= iByte[3:0];
            csum        <= csum ^ iByte;
          end
        end
        B1: begin
          if (accept) begin
            word[23:16] <= iByte;
            csum        <= csum ^ iByte;
          end
        end
        B2: begin
          if (accept) begin
            word[15:8] <= iByte;
            csum       <= csum ^ iByte;
          end
        end
        B3: begin
          if (accept) begin
            word[7:0] <= iByte;
            csum      <= csum ^ iByte;
          end
        end
        // The counter holds on the final word so it never reaches N,
        // keeping the address within 0..MAX_WORDS-1.
        WRITE: if (!last_word) addr <= addr + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model feeds a
// write scoreboard; a monitor pops and compares every write strobe.
module tb_program_loader;

  localparam logic [7:0] SYNC = 8'h55;
  localparam int         MAXW = 256;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  iByte;
  logic        iByteValid;
  logic        oReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oWriteData;
  logic        oCpuHold;
  logic        oDone;
  logic        oError;

  int          errors = 0;
  int          checks = 0;
  int          stalls = 0;
  logic [7:0]  frame[$];
  logic [43:0] exp_q[$];

  always #5 Clock = ~Clock;

  program_loader #(.SYNC_BYTE(8'h55), .MAX_WORDS(16'd256)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iByte         (iByte),
    .iByteValid    (iByteValid),
    .oReady        (oReady),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oCpuHold      (oCpuHold),
    .oDone         (oDone),
    .oError        (oError)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is compared against the scoreboard head
  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      if (oReady === 1'b0) stalls++;
      if (oWriteEnable === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                   oWriteAddress, oWriteData);
        end else begin
          chk("write", {20'd0, oWriteAddress, oWriteData}, {20'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Reference model: parses the frame by its rules, pushes expected writes
  function automatic void model(output int used, output bit done, output bit err);
    int         n;
    int         b;
    logic [7:0] x;
    logic [7:0] hb;
    done = 1'b0;
    err  = 1'b0;
    n    = {frame[1], frame[2]};
    x    = frame[1] ^ frame[2];
    if (n > MAXW) begin
      err  = 1'b1;
      used = 3;
      return;
    end
    for (int i = 0; i < n; i++) begin
      b  = 3 + 4 * i;
      hb = frame[b];
      if (hb[7:4] != 4'd0) begin
        err  = 1'b1;
        used = b + 1;
        return;
      end
      exp_q.push_back({16'(i), hb[3:0], frame[b+1], frame[b+2], frame[b+3]});
      x = x ^ frame[b] ^ frame[b+1] ^ frame[b+2] ^ frame[b+3];
    end
    used = 4 + 4 * n;
    done = (frame[3 + 4 * n] == x);
    err  = !done;
  endfunction

  // Drive the first 'used' bytes of the frame; gaps randomly drops valid
  task automatic send_frame(input int used, input bit gaps);
    int idx   = 0;
    int guard = 0;
    while (idx < used && guard < 8 * used + 50) begin
      @(negedge Clock);
      guard++;
      iByte      = frame[idx];
      iByteValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (iByteValid && oReady) idx++;
    end
    checks++;
    if (idx < used) begin
      errors++;
      $display("FAIL send_timeout: got %0d bytes accepted expected %0d", idx, used);
    end
    @(negedge Clock);
    iByteValid = 1'b0;
  endtask

  task automatic run_frame(input string name, input bit gaps);
    int used;
    bit d;
    bit e;
    int nw;
    exp_q.delete();
    model(used, d, e);
    nw     = exp_q.size();
    stalls = 0;
    send_frame(used, gaps);
    repeat (3) @(negedge Clock);
    chk({name, "_done"},   64'(oDone),        64'(d));
    chk({name, "_error"},  64'(oError),       64'(e));
    chk({name, "_hold"},   64'(oCpuHold),     64'(!d));
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_stalls"}, 64'(stalls),       64'(nw));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ready"}, 64'(oReady),        64'd1);
    chk({name, "_we"},    64'(oWriteEnable),  64'd0);
    chk({name, "_addr"},  64'(oWriteAddress), 64'd0);
    chk({name, "_data"},  64'(oWriteData),    64'd0);
    chk({name, "_hold"},  64'(oCpuHold),      64'd0);
    chk({name, "_done"},  64'(oDone),         64'd0);
    chk({name, "_error"}, 64'(oError),        64'd0);
  endtask

  task automatic set_frame_a;
    // Two words 1234567 and ABCDEF0; XOR of count and data bytes is 9A
    frame = '{8'h55, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67,
              8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h9A};
  endtask

  task automatic build_random(input int n, input int mode, input bit bad_sum);
    logic [27:0] w;
    logic [7:0]  x;
    int          bad;
    frame = '{SYNC, 8'(n >> 8), 8'(n)};
    bad   = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      w = 28'($urandom());
      if (i % 3 == 1) w[23:0] = 24'h555555;
      frame.push_back((mode == 2 && i == bad) ? {4'(1 + $urandom_range(0, 14)), w[27:24]}
                                              : {4'd0, w[27:24]});
      frame.push_back(w[23:16]);
      frame.push_back(w[15:8]);
      frame.push_back(w[7:0]);
    end
    x = 8'd0;
    for (int i = 1; i < frame.size(); i++) x = x ^ frame[i];
    if (bad_sum) x = x ^ 8'(1 + $urandom_range(0, 254));
    frame.push_back(x);
  endtask

  initial begin
    Reset      = 1'b1;
    iByte      = 8'd0;
    iByteValid = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge Clock);
    Reset = 1'b0;

    set_frame_a();
    run_frame("two_words", 1'b0);

    // A non-sync byte in DONE is dropped
    frame = '{8'h00};
    send_frame(1, 1'b0);
    @(negedge Clock);
    chk("done_drop", 64'(oDone), 64'd1);

    frame = '{8'h55, 8'h00, 8'h00, 8'h00};
    run_frame("empty_ok", 1'b0);
    frame = '{8'h55, 8'h00, 8'h00, 8'h01};
    run_frame("empty_badsum", 1'b1);
    frame = '{8'h55, 8'h00, 8'h01, 8'hF0};
    run_frame("bad_nibble", 1'b0);
    frame = '{8'h55, 8'h01, 8'h01};
    run_frame("too_many", 1'b0);
    frame = '{8'h55, 8'h00, 8'h01, 8'h05, 8'h55, 8'h55, 8'h55, 8'h50};
    run_frame("sync_as_data", 1'b0);

    build_random(MAXW, 0, 1'b0);
    run_frame("max_words", 1'b0);

    for (int k = 0; k < 20; k++) begin
      int mode;
      mode = $urandom_range(0, 2);
      build_random($urandom_range(1, 8), mode, mode == 1);
      run_frame("random", k[0]);
    end

    // Reset after B2 of the first word, then a fresh frame from address 0
    frame = '{8'h55, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45};
    send_frame(6, 1'b0);
    chk("pre_reset_hold", 64'(oCpuHold), 64'd1);
    Reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    @(negedge Clock);
    Reset = 1'b0;
    set_frame_a();
    run_frame("after_reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
